// File: rtl/raster_to_block.sv
// raster_to_block: buffers one B-row strip of a raster image and replays it as
// BxB windows, left to right, on a flat N*B*B bus in dct2d packing.

module raster_to_block_row #(
    parameter int N     = 10,
    parameter int IMG_W = 128,
    parameter int B     = 8,
    parameter int CW    = 7
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [CW-1:0]         wcol,
    input  logic [N-1:0]          wdata,
    input  logic [CW-1:0]         rbase,
    output logic [B-1:0][N-1:0]   rdata
);
    // Storage is never reset: a strip is always fully rewritten before it is read.
    logic [IMG_W-1:0][N-1:0] mem;

    always_ff @(posedge clk)
        if (we) mem[wcol] <= wdata;

    assign rdata = mem[rbase +: B];
endmodule

module raster_to_block #(
    parameter int N     = 10,
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int B     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [N-1:0]  pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic [N*B*B-1:0]     win_out,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic                 frame_done
);
    localparam int NK = IMG_W / B;
    localparam int NS = IMG_H / B;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (B > 1) ? $clog2(B) : 1;
    localparam int KW = (NK > 1) ? $clog2(NK) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    if (B < 2 || (IMG_W % B) != 0 || (IMG_H % B) != 0) begin : g_bad_geom
        $error("raster_to_block: need B >= 2 and IMG_W, IMG_H multiples of B");
    end

    typedef enum logic {FILL, EMIT} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] c;
    logic [RW-1:0] r;
    logic [KW-1:0] k, rd_k;
    logic [SW-1:0] s;
    logic [CW-1:0] rd_base;

    logic pix_acc, win_acc, last_pix, last_win, last_strip;
    logic win_load, win_valid_nxt, pix_ready_nxt, frame_done_nxt;

    logic [B-1:0][B-1:0][N-1:0] row_data;

    assign pix_acc    = pix_valid && pix_ready;
    assign win_acc    = win_valid && win_ready;
    assign last_pix   = (r == RW'(B-1)) && (c == CW'(IMG_W-1));
    assign last_win   = (k == KW'(NK-1));
    assign last_strip = (s == SW'(NS-1));

    // While a window is on the bus, read ahead so a handshake reloads in the same edge.
    assign rd_k    = (win_valid && !last_win) ? k + KW'(1) : k;
    assign rd_base = CW'(rd_k * B);

    for (genvar i = 0; i < B; i++) begin : g_row
        raster_to_block_row #(.N(N), .IMG_W(IMG_W), .B(B), .CW(CW)) u_row (
            .clk   (clk),
            .we    (pix_acc && r == RW'(i)),
            .wcol  (c),
            .wdata (pix_in),
            .rbase (rd_base),
            .rdata (row_data[i])
        );
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= FILL;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (pix_acc && last_pix) state_nxt = EMIT;
            EMIT: if (win_acc && last_win) state_nxt = FILL;
        endcase
    end

    always_comb begin
        win_load       = 1'b0;
        win_valid_nxt  = win_valid;
        frame_done_nxt = 1'b0;
        pix_ready_nxt  = (state_nxt == FILL);
        if (state == EMIT) begin
            if (!win_valid) begin
                win_load      = 1'b1;
                win_valid_nxt = 1'b1;
            end else if (win_acc) begin
                if (last_win) begin
                    win_valid_nxt  = 1'b0;
                    frame_done_nxt = last_strip;
                end else begin
                    win_load = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            c <= '0;
            r <= '0;
            k <= '0;
            s <= '0;
        end else begin
            if (pix_acc) begin
                if (c == CW'(IMG_W-1)) begin
                    c <= '0;
                    r <= (r == RW'(B-1)) ? '0 : r + RW'(1);
                end else begin
                    c <= c + CW'(1);
                end
            end
            if (win_acc) begin
                if (last_win) begin
                    k <= '0;
                    s <= last_strip ? '0 : s + SW'(1);
                end else begin
                    k <= k + KW'(1);
                end
            end
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pix_ready  <= 1'b0;
            win_valid  <= 1'b0;
            win_out    <= '0;
            frame_done <= 1'b0;
        end else begin
            pix_ready  <= pix_ready_nxt;
            win_valid  <= win_valid_nxt;
            frame_done <= frame_done_nxt;
            if (win_load) win_out <= row_data;
        end
endmodule

// File: tb/tb_raster_to_block.sv
// Scoreboard bench for raster_to_block on a 16x16 image with 8x8 windows.
module tb_raster_to_block;
  localparam int N = 10, IMG_W = 16, IMG_H = 16, B = 8;
  localparam int NK = IMG_W / B, NS = IMG_H / B, WW = N * B * B, TMO = 2000;

  typedef struct { logic [WW-1:0] data; int k; bit last; } exp_t;

  logic          clk = 1'b0, rst = 1'b1;
  logic [N-1:0]  pix_in = '0;
  logic          pix_valid = 1'b0, pix_ready;
  logic [WW-1:0] win_out;
  logic          win_valid, win_ready = 1'b0, frame_done;

  raster_to_block #(.N(N), .IMG_W(IMG_W), .IMG_H(IMG_H), .B(B)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .win_out(win_out), .win_valid(win_valid), .win_ready(win_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // golden model of the strip fill
  logic [N-1:0] img [IMG_H][IMG_W];
  int mr = 0, mc = 0, ms = 0;
  exp_t sb_q[$];
  bit abort = 0;

  task automatic push_strip(input int s);
    exp_t e;
    for (int k = 0; k < NK; k++) begin
      e.data = '0;
      for (int m = 0; m < B; m++)
        for (int n = 0; n < B; n++)
          e.data[(m*B+n)*N +: N] = img[s*B+m][k*B+n];
      e.k = k;
      e.last = (s == NS-1) && (k == NK-1);
      sb_q.push_back(e);
    end
  endtask

  task automatic model_accept(input logic [N-1:0] v);
    img[ms*B+mr][mc] = v;
    if (mc == IMG_W-1) begin
      mc = 0;
      if (mr == B-1) begin
        mr = 0;
        push_strip(ms);
        ms = (ms == NS-1) ? 0 : ms + 1;
      end else mr++;
    end else mc++;
  endtask

  task automatic send_pix(input logic [N-1:0] v, input int gap);
    int n = 0;
    bit ok = 0;
    while (!ok && n < TMO) begin
      @(negedge clk);
      pix_in = v;
      pix_valid = ($urandom_range(0, 99) >= gap);
      ok = pix_valid && pix_ready;
      n++;
    end
    chk("pix_accept", WW'(ok), WW'(1));
    if (!ok) begin
      pix_valid = 1'b0;
      abort = 1;
      return;
    end
    @(posedge clk);
    model_accept(v);
    #1 pix_valid = 1'b0;
  endtask

  task automatic send_frame(input int mode, input int gap, input int npix);
    logic [N-1:0] v;
    for (int i = 0; i < npix; i++) begin
      if (abort) break;
      case (mode)
        0: v = N'(i);
        1: v = N'($urandom);
        default: v = (i % 2 == 0) ? N'(-512) : N'(511);
      endcase
      send_pix(v, gap);
    end
  endtask

  // monitor / scoreboard side
  bit mon_en = 0, hold_pend = 0, fd_exp = 0, ramp_chk = 0;
  int rdy_mode = 0, stall = 0, n_win = 0, n_fd = 0, fwin = 0;
  logic [WW-1:0] held;
  exp_t me;

  always @(negedge clk) if (mon_en) begin
    if (hold_pend) begin
      chk("hold_valid", WW'(win_valid), WW'(1));
      chk("hold_data", win_out, held);
      hold_pend = 0;
    end
    case (rdy_mode)
      0: win_ready = 1'b1;
      1: win_ready = !(win_valid && sb_q.size() > 0 && sb_q[0].k == 0 && stall < 5);
      default: win_ready = ($urandom_range(0, 9) < 7);
    endcase
    if (win_valid) chk("pix_ready_emit", WW'(pix_ready), WW'(0));
    if (frame_done) n_fd++;
    if (frame_done || fd_exp) chk("frame_done", WW'(frame_done), WW'(fd_exp));
    fd_exp = 0;
    if (win_valid && win_ready) begin
      stall = 0;
      if (sb_q.size() == 0) chk("unexpected_win", WW'(1), WW'(0));
      else begin
        me = sb_q.pop_front();
        chk("win", win_out, me.data);
        if (ramp_chk && fwin == 1) begin
          chk("w1_e00", WW'(win_out[0 +: N]), WW'(8));
          chk("w1_e77", WW'(win_out[(7*B+7)*N +: N]), WW'(127));
        end
        if (ramp_chk && fwin == 3) begin
          chk("w3_e00", WW'(win_out[0 +: N]), WW'(136));
          chk("w3_e77", WW'(win_out[(7*B+7)*N +: N]), WW'(255));
        end
        n_win++;
        fd_exp = me.last;
        fwin = me.last ? 0 : fwin + 1;
      end
    end else if (win_valid) begin
      held = win_out;
      hold_pend = 1;
      stall++;
    end
  end

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || win_valid) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", WW'(n >= TMO), WW'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input int mode, input int gap, input int rmode, input bit ramp);
    int w0, f0;
    w0 = n_win;
    f0 = n_fd;
    rdy_mode = rmode;
    ramp_chk = ramp;
    send_frame(mode, gap, IMG_W * IMG_H);
    drain();
    chk("frame_wins", WW'(n_win - w0), WW'(NK * NS));
    chk("frame_done_cnt", WW'(n_fd - f0), WW'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_ready", WW'(pix_ready), WW'(0));
    chk("rst_win_valid", WW'(win_valid), WW'(0));
    chk("rst_win_out", win_out, WW'(0));
    chk("rst_frame_done", WW'(frame_done), WW'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", WW'(pix_ready), WW'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_win_valid", WW'(win_valid), WW'(0));
    end
    mon_en = 1;

    run_frame(0, 0, 0, 1);   // ramp, continuous
    run_frame(1, 0, 1, 0);   // random data, 5-cycle stall on each strip's window 0
    run_frame(2, 30, 2, 0);  // signed extremes, valid gaps, random ready
    run_frame(0, 0, 0, 1);   // two consecutive ramp frames
    run_frame(0, 0, 0, 1);

    // reset in the middle of a strip
    send_frame(0, 0, 100);
    mon_en = 0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pix_ready", WW'(pix_ready), WW'(0));
    chk("mid_rst_win_valid", WW'(win_valid), WW'(0));
    chk("mid_rst_win_out", win_out, WW'(0));
    chk("mid_rst_frame_done", WW'(frame_done), WW'(0));
    sb_q.delete();
    hold_pend = 0;
    fd_exp = 0;
    stall = 0;
    fwin = 0;
    mr = 0;
    mc = 0;
    ms = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_rst", WW'(pix_ready), WW'(1));
    mon_en = 1;
    run_frame(0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
